instr_fetch_buffer: RTL and testbench



---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 70 +++++++
 rtl/instr_fetch_buffer.sv | 96 +++++++++
 tb/tb_instr_fetch_buffer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and sizing for the instruction prefetch stage.
package fetch_pkg;

  localparam int INSTR_BYTES = 4;
  localparam int FIFO_DEPTH  = 4;
  localparam int PTR_W       = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched words; flush beats push and pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int AW    = PTR_W,
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  fetch_entry_t  data_i,
  output fetch_entry_t  head_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];

  assign do_push = push_i;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + AW'(1);
      if (do_pop)  rd_d = rd_q + AW'(1);
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      if (do_push && !flush_i) mem_q[wr_q] <= data_i;
    end
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (rst_i || flush_i)
    push_i |-> !full_o
  );

endmodule

// File: rtl/instr_fetch_buffer.sv
// Prefetch stage: issues word fetches and queues them for LoadIR.
module instr_fetch_buffer
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = FIFO_DEPTH,
  parameter logic [63:0] RESET_PC = 64'h0,
  localparam int         AW       = $clog2(DEPTH),
  localparam int         CW       = AW + 1
) (
  input  logic          clk,
  input  logic          Reset,
  input  logic          redirect,
  input  logic [63:0]   redirect_pc,
  output logic          imem_req,
  output logic [63:0]   imem_addr,
  input  logic [31:0]   imem_data,
  output logic          instr_valid,
  output logic [31:0]   instr,
  output logic [63:0]   instr_pc,
  input  logic          instr_ready,
  output logic [CW-1:0] count,
  output logic          exc_misaligned
);

  logic [63:0]  fetch_pc_q, fetch_pc_d;
  logic [63:0]  req_pc_q, req_pc_d;
  logic         infl_q, infl_d;
  logic         misal_q, misal_d;
  logic [CW:0]  occ;
  logic         full;
  logic         empty;
  logic         push;
  fetch_entry_t wdata;
  fetch_entry_t head;

  // Pops in the same cycle are ignored here on purpose.
  assign occ = {1'b0, count} + (CW+1)'(infl_q);
  assign imem_req = ~Reset & ~redirect & ~misal_q & ~full
                  & (occ < (CW+1)'(DEPTH));
  assign imem_addr = fetch_pc_q;
  assign exc_misaligned = misal_q;

  assign push = infl_q & ~redirect & ~Reset;
  assign wdata.pc = req_pc_q;
  assign wdata.instr = imem_data;

  assign instr_valid = ~empty;
  assign instr = head.instr;
  assign instr_pc = head.pc;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    infl_d     = 1'b0;
    misal_d    = misal_q;
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      misal_d    = (redirect_pc[1:0] != 2'b00);
    end else if (imem_req) begin
      infl_d     = 1'b1;
      req_pc_d   = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + 64'(INSTR_BYTES);
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      infl_q     <= 1'b0;
      misal_q    <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      infl_q     <= infl_d;
      misal_q    <= misal_d;
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_fifo (
    .clk    (clk),
    .rst_i  (Reset),
    .flush_i(redirect),
    .push_i (push),
    .pop_i  (instr_ready),
    .data_i (wdata),
    .head_o (head),
    .count_o(count),
    .full_o (full),
    .empty_o(empty)
  );

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Directed bench for instr_fetch_buffer with a 1-cycle memory model.
module tb_instr_fetch_buffer;

  logic        clk = 1'b0;
  logic        Reset;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic [31:0] imem_data;
  logic        instr_valid;
  logic [31:0] instr;
  logic [63:0] instr_pc;
  logic        instr_ready;
  logic [2:0]  count;
  logic        exc_misaligned;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Word at address k holds k.
  always @(posedge clk) imem_data <= imem_addr[31:0];

  instr_fetch_buffer dut (
    .clk           (clk),
    .Reset         (Reset),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_ready   (instr_ready),
    .count         (count),
    .exc_misaligned(exc_misaligned)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    Reset = 1'b1;
    cyc();
    cyc();
    Reset = 1'b0;
    #1;
  endtask

  int cnt_exp [6] = '{0, 0, 1, 2, 3, 4};

  initial begin
    Reset = 1'b1;
    redirect = 1'b0;
    redirect_pc = '0;
    instr_ready = 1'b1;
    cyc();
    cyc();
    #1;
    check("rst_req", imem_req, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_instr", instr, 0);
    check("rst_pc", instr_pc, 0);
    check("rst_count", count, 0);
    check("rst_exc", exc_misaligned, 0);
    Reset = 1'b0;
    #1;

    // Streaming with the consumer always ready.
    for (int c = 0; c < 8; c++) begin
      check("s_req", imem_req, 1);
      check("s_addr", imem_addr, 64'(4 * c));
      if (c >= 2) begin
        check("s_valid", instr_valid, 1);
        check("s_pc", instr_pc, 64'(4 * (c - 2)));
        check("s_instr", instr, 64'(4 * (c - 2)));
      end else begin
        check("s_nvalid", instr_valid, 0);
      end
      cyc();
      #1;
    end

    // Fill with the consumer stalled, then drain.
    instr_ready = 1'b0;
    reset_dut();
    for (int c = 0; c < 6; c++) begin
      check("f_req", imem_req, (c < 4) ? 1 : 0);
      check("f_addr", imem_addr, 64'(4 * ((c < 4) ? c : 4)));
      check("f_count", count, 64'(cnt_exp[c]));
      cyc();
      #1;
    end
    instr_ready = 1'b1;
    #1;
    check("d_req0", imem_req, 0);
    for (int c = 0; c < 6; c++) begin
      check("d_valid", instr_valid, 1);
      check("d_pc", instr_pc, 64'(4 * c));
      if (c == 1) check("d_addr", imem_addr, 64'h10);
      cyc();
      #1;
    end

    // Redirect with 3 buffered and one in flight.
    instr_ready = 1'b0;
    reset_dut();
    repeat (4) begin
      cyc();
      #1;
    end
    check("r_pre_cnt", count, 3);
    redirect = 1'b1;
    redirect_pc = 64'h100;
    #1;
    check("r_req_blk", imem_req, 0);
    cyc();
    redirect = 1'b0;
    #1;
    check("r_count", count, 0);
    check("r_valid", instr_valid, 0);
    check("r_req", imem_req, 1);
    check("r_addr", imem_addr, 64'h100);
    cyc();
    #1;
    check("r_drop", count, 0);
    check("r_nvalid", instr_valid, 0);
    cyc();
    #1;
    check("r_valid2", instr_valid, 1);
    check("r_pc", instr_pc, 64'h100);
    check("r_instr", instr, 64'h100);

    // Misaligned redirect then recovery.
    redirect = 1'b1;
    redirect_pc = 64'h102;
    #1;
    cyc();
    redirect = 1'b0;
    #1;
    check("m_count", count, 0);
    check("m_exc", exc_misaligned, 1);
    for (int i = 0; i < 10; i++) begin
      check("m_req", imem_req, 0);
      cyc();
      #1;
    end
    check("m_exc_hold", exc_misaligned, 1);
    check("m_nvalid", instr_valid, 0);
    redirect = 1'b1;
    redirect_pc = 64'h200;
    #1;
    cyc();
    redirect = 1'b0;
    #1;
    check("a_exc", exc_misaligned, 0);
    check("a_req", imem_req, 1);
    check("a_addr", imem_addr, 64'h200);
    cyc();
    #1;
    cyc();
    #1;
    check("a_valid", instr_valid, 1);
    check("a_pc", instr_pc, 64'h200);

    // Redirect alongside a pop of a valid head.
    instr_ready = 1'b1;
    redirect = 1'b1;
    redirect_pc = 64'h300;
    #1;
    check("p_pre_valid", instr_valid, 1);
    cyc();
    redirect = 1'b0;
    #1;
    check("p_count", count, 0);
    check("p_addr", imem_addr, 64'h300);
    cyc();
    #1;
    check("p_nvalid", instr_valid, 0);
    cyc();
    #1;
    check("p_valid", instr_valid, 1);
    check("p_pc", instr_pc, 64'h300);

    // Reset beats a simultaneous redirect while occupancy is full.
    instr_ready = 1'b0;
    redirect = 1'b1;
    redirect_pc = 64'h400;
    #1;
    cyc();
    redirect = 1'b0;
    #1;
    repeat (4) begin
      cyc();
      #1;
    end
    check("x_pre_cnt", count, 3);
    check("x_pre_req", imem_req, 0);
    Reset = 1'b1;
    redirect = 1'b1;
    redirect_pc = 64'h500;
    #1;
    check("x_req_rst", imem_req, 0);
    cyc();
    Reset = 1'b0;
    redirect = 1'b0;
    #1;
    check("x_count", count, 0);
    check("x_valid", instr_valid, 0);
    check("x_req", imem_req, 1);
    check("x_addr", imem_addr, 64'h0);
    check("x_exc", exc_misaligned, 0);
    cyc();
    #1;
    check("x_drop", count, 0);
    cyc();
    #1;
    check("x_valid2", instr_valid, 1);
    check("x_pc", instr_pc, 64'h0);
    check("x_instr", instr, 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
